// File: rtl/mips32_pkg.sv
// mips32_pkg: shared MIPS32 opcodes, instruction-type codes and fetch-stage types
package mips32_pkg;
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_SLL  = 6'd5;
    localparam logic [5:0] OP_SRL  = 6'd6;
    localparam logic [5:0] OP_SLT  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SUBI = 6'd9;
    localparam logic [5:0] OP_LW   = 6'd10;
    localparam logic [5:0] OP_SW   = 6'd11;
    localparam logic [5:0] OP_BEQZ = 6'd12;
    localparam logic [5:0] OP_HLT  = 6'd63;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} instr_type_t;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } fetch_entry_t;
endpackage

// File: rtl/mips32_sync_fifo.sv
// mips32_sync_fifo: synchronous FIFO with push, pop and flush
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (head, zero when empty),
//        flush (clears contents, wins over push/pop), count, full, empty.
module mips32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop = pop && !empty && !flush;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: instruction-fetch front end feeding the ID stage
// Ports: clk, rst (sync, active-high);
//        imem_req/imem_addr/imem_ack/imem_rdata: word-read handshake to instruction memory;
//        redirect_valid/redirect_pc: taken-branch flush from EX; halt: stop new issues;
//        id_valid/id_ready/id_ir/id_npc: buffered instruction and fetch address + 1 to ID.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_ir,
    output logic [31:0]       id_npc
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [ADDR_W-1:0] old_addr;
    logic push, pop, flush, full, empty;
    logic [CW-1:0] count;
    fetch_entry_t wentry, head;

    assign pop = id_valid && id_ready;
    assign imem_req = state != IDLE;
    // A discarded request keeps presenting the address it was issued with.
    assign imem_addr = state == DISCARD ? old_addr : pc[ADDR_W-1:0];
    assign wentry = '{ir: imem_rdata, npc: pc + 32'd1};
    assign id_valid = !empty;
    assign id_ir = head.ir;
    assign id_npc = head.npc;

    mips32_sync_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .wdata(wentry),
        .pop(pop),
        .flush(flush),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt = pc;
        push = 1'b0;
        flush = 1'b0;
        case (state)
            IDLE:
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    flush = 1'b1;
                end else if (!halt && !full) state_nxt = REQ;
            REQ:
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    flush = 1'b1;
                    state_nxt = !imem_ack ? DISCARD : halt ? IDLE : REQ;
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_nxt = pc + 32'd1;
                    // Keep issuing only if the FIFO will still have room after this push.
                    state_nxt = (!halt && (pop || count < CW'(DEPTH - 1))) ? REQ : IDLE;
                end
            DISCARD: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    flush = 1'b1;
                end
                if (imem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            old_addr <= RESET_PC[ADDR_W-1:0];
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            old_addr <= imem_addr;
        end
    end
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb_mips32_fetch_queue: directed vector bench for the fetch queue
module tb_mips32_fetch_queue;
    logic clk = 1'b0;
    logic rst, imem_req, imem_ack, redirect_valid, halt, id_valid, id_ready;
    logic [9:0] imem_addr;
    logic [31:0] imem_rdata, redirect_pc, id_ir, id_npc;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {22'd0, a[9:0]};
    endfunction

    assign imem_rdata = imem_ack ? mem_word({22'd0, imem_addr}) : 32'hDEAD_BEEF;

    mips32_fetch_queue dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_ir(id_ir),
        .id_npc(id_npc)
    );

    typedef struct {
        logic ack;
        logic ready;
        logic req;
        logic [9:0] addr;
        logic valid;
        logic [31:0] npc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic req, input logic [9:0] addr,
                           input logic valid, input logic [31:0] npc);
        chk({nm, " req"}, {31'd0, imem_req}, {31'd0, req});
        chk({nm, " addr"}, {22'd0, imem_addr}, {22'd0, addr});
        chk({nm, " valid"}, {31'd0, id_valid}, {31'd0, valid});
        if (valid) begin
            chk({nm, " npc"}, id_npc, npc);
            chk({nm, " ir"}, id_ir, mem_word(npc - 32'd1));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 10'd1, 1'b1, 32'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 10'd2, 1'b1, 32'd2};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 10'd3, 1'b1, 32'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 10'd4, 1'b1, 32'd4};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 10'd5, 1'b1, 32'd4};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 10'd6, 1'b1, 32'd4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 10'd7, 1'b1, 32'd4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 10'd7, 1'b1, 32'd4};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 10'd7, 1'b1, 32'd4};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 10'd7, 1'b1, 32'd5};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 10'd7, 1'b1, 32'd6};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 10'd8, 1'b1, 32'd7};

        do_reset();
        chk("reset req", {31'd0, imem_req}, 32'd0);
        chk("reset addr", {22'd0, imem_addr}, 32'd0);
        chk("reset valid", {31'd0, id_valid}, 32'd0);
        chk("reset ir", id_ir, 32'd0);
        chk("reset npc", id_npc, 32'd0);

        for (int i = 0; i < 14; i++) begin
            imem_ack = tbl[i].ack;
            id_ready = tbl[i].ready;
            chk_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].npc);
            tick();
        end

        do_reset();
        id_ready = 1'b1;
        tick();
        chk_out("wait0", 1'b1, 10'd0, 1'b0, 32'd0);
        tick();
        tick();
        chk_out("wait2", 1'b1, 10'd0, 1'b0, 32'd0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk_out("wait_ack", 1'b1, 10'd1, 1'b1, 32'd1);
        tick();
        chk_out("wait_pop", 1'b1, 10'd1, 1'b0, 32'd0);

        do_reset();
        id_ready = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        imem_ack = 1'b0;
        id_ready = 1'b0;
        chk_out("redir_pre", 1'b1, 10'd5, 1'b1, 32'd5);
        redirect_valid = 1'b1;
        redirect_pc = 32'd12;
        tick();
        chk_out("redir_disc", 1'b1, 10'd5, 1'b0, 32'd0);
        redirect_pc = 32'd20;
        tick();
        redirect_valid = 1'b0;
        chk_out("redir_disc2", 1'b1, 10'd5, 1'b0, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk_out("redir_drop", 1'b0, 10'd20, 1'b0, 32'd0);
        tick();
        chk_out("redir_req", 1'b1, 10'd20, 1'b0, 32'd0);
        tick();
        chk_out("redir_first", 1'b1, 10'd21, 1'b1, 32'd21);

        do_reset();
        id_ready = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk_out("coin_pre", 1'b1, 10'd3, 1'b1, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'd8;
        tick();
        redirect_valid = 1'b0;
        chk_out("coin_flush", 1'b1, 10'd8, 1'b0, 32'd0);
        tick();
        chk_out("coin_next", 1'b1, 10'd9, 1'b1, 32'd9);

        do_reset();
        id_ready = 1'b1;
        tick();
        halt = 1'b1;
        tick();
        chk_out("halt_out", 1'b1, 10'd0, 1'b0, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk_out("halt_push", 1'b0, 10'd1, 1'b1, 32'd1);
        tick();
        chk_out("halt_drain", 1'b0, 10'd1, 1'b0, 32'd0);
        halt = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk_out("rst_pre", 1'b1, 10'd1, 1'b0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rst_mid", 1'b0, 10'd0, 1'b0, 32'd0);
        tick();
        chk_out("rst_reissue", 1'b1, 10'd0, 1'b0, 32'd0);

        do_reset();
        id_ready = 1'b1;
        imem_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk_out("wrap_idle", 1'b0, 10'h3FF, 1'b0, 32'd0);
        tick();
        chk_out("wrap_req", 1'b1, 10'h3FF, 1'b0, 32'd0);
        tick();
        chk_out("wrap_push", 1'b1, 10'd0, 1'b1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
